// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and a one-deep
// holding register with acknowledge, framing-error and overrun reporting.
module uart_receiver #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       com_RxD,
    input  logic       data_ack,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic          sync1_q;
    logic          rx_s_q;
    logic          rx_p_q;
    logic [2:0]    vld_q;
    logic          fall;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          done;
    logic          ferr_d;

    logic [7:0]    data_q;
    logic          rdy_q;
    logic          ferr_q;
    logic          ovr_q;

    // vld_q marks when each sync stage holds a real line sample rather than
    // its reset value, so a line held low through reset is not seen as an edge.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            vld_q   <= 3'b000;
        end else begin
            sync1_q <= com_RxD;
            rx_s_q  <= sync1_q;
            rx_p_q  <= rx_s_q;
            vld_q   <= {vld_q[1:0], 1'b1};
        end
    end

    assign fall = vld_q[2] & rx_p_q & ~rx_s_q;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done    = rx_s_q;
                    ferr_d  = ~rx_s_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // An ack in the completion cycle frees the holding register for the new byte.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            data_q <= 8'h00;
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= done & rdy_q & ~data_ack;
            if (done && (!rdy_q || data_ack)) begin
                data_q <= shift_q;
                rdy_q  <= 1'b1;
            end else if (data_ack) begin
                rdy_q <= 1'b0;
            end
        end
    end

    assign data       = data_q;
    assign data_ready = rdy_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       com_RxD = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = -1;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int busy_cnt = 0;
    logic rdy_prev = 1'b0;
    int f0, o0, b0;

    uart_receiver #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk50M    (clk),
        .rst       (rst),
        .com_RxD   (com_RxD),
        .data_ack  (data_ack),
        .data      (data),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (data_ready && !rdy_prev) rise_cyc = cyc;
        rdy_prev = data_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 160-cycle 8N1 frame; optional ack or reset pulse at cycle offset.
    task automatic send(input logic [7:0] b, input logic stopb,
                        input int ack_at, input int rst_at);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        fall_cyc = cyc;
        for (int n = 0; n < 160; n++) begin
            com_RxD  = fr[n/16];
            data_ack = (n == ack_at);
            rst      = (n == rst_at);
            wait_cyc(1);
        end
        com_RxD  = 1'b1;
        data_ack = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic ack();
        data_ack = 1'b1;
        wait_cyc(1);
        data_ack = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ready", 32'(data_ready), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_cyc(5);

        f0 = ferr_cnt;
        send(8'h3C, 1'b0, -1, -1);
        wait_cyc(4);
        chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("ferr_ready", 32'(data_ready), 32'h0);
        chk("ferr_data", 32'(data), 32'h00);

        f0 = ferr_cnt;
        b0 = busy_cnt;
        com_RxD = 1'b0;
        wait_cyc(4);
        com_RxD = 1'b1;
        wait_cyc(20);
        chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
        chk("glitch_busy_end", 32'(busy), 32'h0);
        chk("glitch_ready", 32'(data_ready), 32'h0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send(8'hA5, 1'b1, -1, -1);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_ready", 32'(data_ready), 32'h1);
        chk("a5_latency", 32'(rise_cyc - fall_cyc), 32'd155);
        chk("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("a5_ovr", 32'(ovr_cnt - o0), 32'd0);

        ack();
        chk("ack_ready", 32'(data_ready), 32'h0);
        chk("ack_data_hold", 32'(data), 32'hA5);
        ack();
        chk("ack_idle_ready", 32'(data_ready), 32'h0);

        o0 = ovr_cnt;
        send(8'h11, 1'b1, -1, -1);
        send(8'h22, 1'b1, -1, -1);
        chk("ovr_data", 32'(data), 32'h11);
        chk("ovr_ready", 32'(data_ready), 32'h1);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        ack();

        o0 = ovr_cnt;
        send(8'h11, 1'b1, -1, -1);
        send(8'h22, 1'b1, 154, -1);
        chk("ackcmp_data", 32'(data), 32'h22);
        chk("ackcmp_ready", 32'(data_ready), 32'h1);
        chk("ackcmp_ovr", 32'(ovr_cnt - o0), 32'd0);
        ack();

        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send(8'hFF, 1'b1, -1, 88);
        wait_cyc(20);
        chk("abort_data", 32'(data), 32'h00);
        chk("abort_ready", 32'(data_ready), 32'h0);
        send(8'h5A, 1'b1, -1, -1);
        chk("post_rst_data", 32'(data), 32'h5A);
        chk("post_rst_ready", 32'(data_ready), 32'h1);
        chk("post_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("post_rst_ovr", 32'(ovr_cnt - o0), 32'd0);
        ack();

        f0 = ferr_cnt;
        com_RxD = 1'b0;
        wait_cyc(640);
        com_RxD = 1'b1;
        wait_cyc(32);
        chk("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("break_ready", 32'(data_ready), 32'h0);
        send(8'h81, 1'b1, -1, -1);
        chk("after_break_data", 32'(data), 32'h81);
        chk("after_break_ready", 32'(data_ready), 32'h1);
        chk("after_break_ferr", 32'(ferr_cnt - f0), 32'd1);

        b0 = busy_cnt;
        com_RxD = 1'b0;
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(40);
        chk("low_rst_busy", 32'(busy_cnt - b0), 32'd0);
        chk("low_rst_ready", 32'(data_ready), 32'h0);
        com_RxD = 1'b1;
        wait_cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
